mog_mean_update_seq: RTL and testbench
======================================

# mog_mean_update_seq

Parametrised Gaussian mean-update unit for the mixture-of-Gaussians background-subtraction pipeline. It accepts one Gaussian component per beat and computes the learning rate rho = ALPHA / weight with an iterative divider. When the component matched the pixel, it applies mean' = mean + rho·(pixel − mean). It generalises the fixed 16-bit, fixed-latency mean updater with configurable widths, valid/ready handshakes, a sideband tag and a fast path for unmatched or saturated components.

## Interface
- DATA_W, 8: pixel integer width; mean is unsigned DATA_W.FRAC_W fixed point.
- FRAC_W, 8: fractional bits of mean and rho; divider iterations.
- WEIGHT_W, 8: weight width, unsigned 0.WEIGHT_W fraction.
- ALPHA, 2: global learning rate, unsigned 0.WEIGHT_W (1..2^WEIGHT_W−1).
- TAG_W, 8: sideband width (Gaussian index, sd, etc.), passed through untouched.
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat.
- s_match  in  1  component matched the pixel.
- s_pixel  in  DATA_W  pixel value.
- s_mean  in  DATA_W+FRAC_W  current mean.
- s_weight  in  WEIGHT_W  current weight.
- s_tag  in  TAG_W  sideband.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_match  out  1  registered s_match.
- m_mean  out  DATA_W+FRAC_W  updated mean.
- m_rho  out  FRAC_W+1  rho used, unsigned 1.FRAC_W; 0 when unmatched.
- m_tag  out  TAG_W  registered s_tag.

## Operation
- FSM states: IDLE, DIV, MUL, OUT.
- s_ready = (state == IDLE). A beat is captured on s_valid & s_ready.
- IDLE, capture with s_match=0: go to OUT with m_mean = s_mean and m_rho = 0.
- IDLE, capture with s_match=1 and s_weight <= ALPHA (includes weight 0): rho = 1<<FRAC_W (saturated), go to MUL.
- IDLE, capture with s_match=1 and s_weight > ALPHA: load the restoring divider with dividend ALPHA<<FRAC_W and divisor s_weight, go to DIV.
- DIV: one quotient bit per cycle, MSB first, for FRAC_W cycles via an iteration counter. The quotient is < 2^FRAC_W. When the counter reaches FRAC_W−1, go to MUL.
- MUL: diff = (pixel<<FRAC_W) − mean, signed DATA_W+FRAC_W+1 bits.
  - prod = diff·rho, signed.
  - delta = prod >>> FRAC_W (arithmetic shift, floor).
  - m_mean = mean + delta, truncated to DATA_W+FRAC_W.
  - Because rho ≤ 1, the result always lies between mean and pixel<<FRAC_W, so no overflow and no clamp.
  - Go to OUT.
- OUT: m_valid=1. On m_ready, go to IDLE. m_* are held stable while m_valid & !m_ready.
- m_match and m_tag are captured at acceptance and held until the next acceptance.
- Reset (asynchronous, any state including mid-DIV): state=IDLE, in-flight beat discarded.
  - Reset values: s_ready=1 after release, m_valid=0, m_match=0, m_mean=0, m_rho=0, m_tag=0, counter=0.

## Timing
- Acceptance edge N is the edge where s_valid & s_ready = 1.
- Unmatched: m_valid rises after edge N+1 (latency 1).
- Matched, saturated: m_valid after edge N+2.
- Matched, divided: m_valid after edge N+FRAC_W+2 (10 for the default FRAC_W=8).
- Handshake completes on the edge where m_valid & m_ready = 1. s_ready is high the cycle after that edge, so the next acceptance is one cycle later at the earliest.
- Minimum beat spacing is latency + 2 cycles.
- No combinational path from s_* to m_*, or from m_ready to s_ready.

## Configuration
- MOG_MEAN_UPDATE_ROUND_EN defined: in MUL, delta = (prod + (1<<(FRAC_W−1))) >>> FRAC_W, i.e. round half up.
- MOG_MEAN_UPDATE_ROUND_EN undefined: delta = prod >>> FRAC_W (floor).
- Everything else is identical in both builds, including latency and the saturation and bypass rules.

## Test plan
All scenarios use default parameters.
- Unmatched bypass: s_match=0, s_mean=0x6400, s_pixel=200, s_weight=0x80, s_tag=0x5A -> m_mean=0x6400, m_rho=0, m_tag=0x5A, m_valid one cycle after acceptance.
- Divided update: s_match=1, s_mean=0x6400, s_pixel=200, s_weight=0x80 -> m_rho=0x004, m_mean=0x6590, m_valid 10 cycles after acceptance.
- Saturation: s_match=1, s_mean=0x6400, s_pixel=200, with s_weight=0x02 and again with s_weight=0x00 -> m_rho=0x100, m_mean=0xC800, latency 2, no DIV cycles.
- Negative diff and rounding: s_match=1, s_mean=0x6401, s_pixel=0, s_weight=0x60 -> m_rho=0x005; m_mean=0x620C without the macro, 0x620D with MOG_MEAN_UPDATE_ROUND_EN.
- Backpressure: hold m_ready=0 for 5 cycles after m_valid -> m_* stable and s_ready=0 throughout; m_ready=1 -> handshake, s_ready=1 next cycle, back-to-back beat accepted.
- Reset mid-operation: assert reset_n=0 during the 4th DIV cycle -> m_valid=0 and all outputs 0 immediately. After release: s_ready=1, and a fresh beat produces the correct result with no residue from the aborted beat.

Source files
------------

// File: rtl/mog_mean_update_seq_if.sv
// rtl/mog_mean_update_seq_if.sv - component-in / updated-mean-out handshake bundle
interface mog_mean_update_seq_if #(
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int TAG_W    = 8
);
  logic                       s_valid;
  logic                       s_ready;
  logic                       s_match;
  logic [DATA_W-1:0]          s_pixel;
  logic [DATA_W+FRAC_W-1:0]   s_mean;
  logic [WEIGHT_W-1:0]        s_weight;
  logic [TAG_W-1:0]           s_tag;
  logic                       m_valid;
  logic                       m_ready;
  logic                       m_match;
  logic [DATA_W+FRAC_W-1:0]   m_mean;
  logic [FRAC_W:0]            m_rho;
  logic [TAG_W-1:0]           m_tag;

  modport master (
    output s_valid, s_match, s_pixel, s_mean, s_weight, s_tag, m_ready,
    input  s_ready, m_valid, m_match, m_mean, m_rho, m_tag
  );

  modport slave (
    input  s_valid, s_match, s_pixel, s_mean, s_weight, s_tag, m_ready,
    output s_ready, m_valid, m_match, m_mean, m_rho, m_tag
  );
endinterface

// File: rtl/mog_mean_update_seq.sv
// rtl/mog_mean_update_seq.sv - MoG mean update, rho = ALPHA/weight via restoring divider
// Optional: MOG_MEAN_UPDATE_ROUND_EN selects round-half-up for the mean delta.
module mog_mean_update_seq #(
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ALPHA    = 2,
  parameter int TAG_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mog_mean_update_seq_if.slave  io
);
  localparam int MW  = DATA_W + FRAC_W;
  localparam int DW  = MW + 1;
  localparam int PW  = DW + FRAC_W + 2;
  localparam int RMW = WEIGHT_W + 1;
  localparam int CW  = $clog2(FRAC_W + 1);
  localparam logic [WEIGHT_W-1:0] ALPHA_W = WEIGHT_W'(ALPHA);
  localparam logic [FRAC_W:0]     RHO_SAT = (FRAC_W+1)'(1) << FRAC_W;
  localparam logic [CW-1:0]       CNT_LAST = CW'(FRAC_W - 1);

  typedef enum logic [1:0] {IDLE, DIV, MUL, OUT} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [RMW-1:0]      rem_q;
  logic [WEIGHT_W-1:0] div_q;
  logic [FRAC_W:0]     rho_q;
  logic [DATA_W-1:0]   pix_q;
  logic [MW-1:0]       mean_q;
  logic                match_q;
  logic [TAG_W-1:0]    tag_q;
  logic                valid_q;
  logic [MW-1:0]       m_mean_q;
  logic [FRAC_W:0]     m_rho_q;

  logic [RMW:0]           rem_sh;
  logic                   rem_ge;
  logic signed [DW-1:0]   diff;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   prod_r;
  logic signed [PW-1:0]   delta;
  logic [MW-1:0]          mean_d;

  always_comb begin
    rem_sh = {rem_q, 1'b0};
    rem_ge = (rem_sh >= {2'b00, div_q});
    diff   = $signed({1'b0, pix_q, {FRAC_W{1'b0}}}) - $signed({1'b0, mean_q});
    prod   = PW'(diff) * PW'($signed({1'b0, rho_q}));
`ifdef MOG_MEAN_UPDATE_ROUND_EN
    prod_r = prod + (PW'(1) <<< (FRAC_W - 1));
`else
    prod_r = prod;
`endif
    // rho <= 1 keeps the sum between mean and pixel, so truncation never wraps
    delta  = prod_r >>> FRAC_W;
    mean_d = mean_q + MW'(delta);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      rho_q    <= '0;
      pix_q    <= '0;
      mean_q   <= '0;
      match_q  <= 1'b0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      m_mean_q <= '0;
      m_rho_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.s_valid) begin
            match_q <= io.s_match;
            tag_q   <= io.s_tag;
            pix_q   <= io.s_pixel;
            mean_q  <= io.s_mean;
            div_q   <= io.s_weight;
            cnt_q   <= '0;
            if (!io.s_match) begin
              m_mean_q <= io.s_mean;
              m_rho_q  <= '0;
              state_q  <= OUT;
            end else if (io.s_weight <= ALPHA_W) begin
              rho_q   <= RHO_SAT;
              state_q <= MUL;
            end else begin
              // ALPHA < weight, so the dividend's integer part is the first remainder
              rho_q   <= '0;
              rem_q   <= {1'b0, ALPHA_W};
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          if (rem_ge) begin
            rem_q <= RMW'(rem_sh - {2'b00, div_q});
          end else begin
            rem_q <= RMW'(rem_sh);
          end
          rho_q <= {rho_q[FRAC_W-1:0], rem_ge};
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= MUL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        MUL: begin
          m_mean_q <= mean_d;
          m_rho_q  <= rho_q;
          state_q  <= OUT;
        end
        OUT: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (io.m_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.s_ready = (state_q == IDLE);
  assign io.m_valid = valid_q;
  assign io.m_match = match_q;
  assign io.m_mean  = m_mean_q;
  assign io.m_rho   = m_rho_q;
  assign io.m_tag   = tag_q;
endmodule

// File: tb/tb_mog_mean_update_seq.sv
// tb/tb_mog_mean_update_seq.sv - directed vector bench for mog_mean_update_seq
module tb_mog_mean_update_seq;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  mog_mean_update_seq_if #(.DATA_W(8), .FRAC_W(8), .WEIGHT_W(8), .TAG_W(8)) bus ();

  mog_mean_update_seq #(
    .DATA_W(8), .FRAC_W(8), .WEIGHT_W(8), .ALPHA(2), .TAG_W(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        match;
    logic [7:0]  pixel;
    logic [15:0] mean;
    logic [7:0]  weight;
    logic [7:0]  tag;
    logic [15:0] exp_mean;
    logic [8:0]  exp_rho;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input string name, input logic match, input logic [7:0] pixel,
                           input logic [15:0] mean, input logic [7:0] weight, input logic [7:0] tag);
    check({name, ".s_ready_pre"}, 32'(bus.s_ready), 32'd1);
    bus.s_valid  = 1'b1;
    bus.s_match  = match;
    bus.s_pixel  = pixel;
    bus.s_mean   = mean;
    bus.s_weight = weight;
    bus.s_tag    = tag;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.m_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.m_valid) lat = 999;
  endtask

  task automatic check_result(input string name, input logic match, input logic [7:0] tag,
                              input logic [15:0] exp_mean, input logic [8:0] exp_rho);
    check({name, ".m_mean"},  32'(bus.m_mean),  32'(exp_mean));
    check({name, ".m_rho"},   32'(bus.m_rho),   32'(exp_rho));
    check({name, ".m_tag"},   32'(bus.m_tag),   32'(tag));
    check({name, ".m_match"}, 32'(bus.m_match), 32'(match));
  endtask

  task automatic handshake(input string name);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    check({name, ".m_valid_post"}, 32'(bus.m_valid), 32'd0);
    check({name, ".s_ready_post"}, 32'(bus.s_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    send_beat(v.name, v.match, v.pixel, v.mean, v.weight, v.tag);
    wait_valid(lat);
    check({v.name, ".latency"}, 32'(lat), 32'(v.exp_lat));
    check_result(v.name, v.match, v.tag, v.exp_mean, v.exp_rho);
    handshake(v.name);
  endtask

  initial begin
    int lat;
    logic [15:0] exp_neg;
    logic [15:0] exp_small;
    n_cmp = 0;
    n_bad = 0;
`ifdef MOG_MEAN_UPDATE_ROUND_EN
    exp_neg   = 16'h620D;
    exp_small = 16'h1234;
`else
    exp_neg   = 16'h620C;
    exp_small = 16'h1233;
`endif
    vecs[0] = '{"bypass",   1'b0, 8'd200, 16'h6400, 8'h80, 8'h5A, 16'h6400, 9'h000, 1};
    vecs[1] = '{"divided",  1'b1, 8'd200, 16'h6400, 8'h80, 8'h11, 16'h6590, 9'h004, 10};
    vecs[2] = '{"sat_w2",   1'b1, 8'd200, 16'h6400, 8'h02, 8'h22, 16'hC800, 9'h100, 2};
    vecs[3] = '{"sat_w0",   1'b1, 8'd200, 16'h6400, 8'h00, 8'h33, 16'hC800, 9'h100, 2};
    vecs[4] = '{"neg_diff", 1'b1, 8'd0,   16'h6401, 8'h60, 8'h44, exp_neg,  9'h005, 10};
    vecs[5] = '{"w_alpha1", 1'b1, 8'd255, 16'h0000, 8'h03, 8'h55, 16'hA956, 9'h0AA, 10};
    vecs[6] = '{"w_max",    1'b1, 8'h12,  16'h1234, 8'hFF, 8'h66, exp_small, 9'h002, 10};
    vecs[7] = '{"zero_diff",1'b1, 8'd50,  16'h3200, 8'h40, 8'h77, 16'h3200, 9'h008, 10};

    bus.s_valid = 1'b0; bus.s_match = 1'b0; bus.s_pixel = '0; bus.s_mean = '0;
    bus.s_weight = '0; bus.s_tag = '0; bus.m_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst.m_valid", 32'(bus.m_valid), 32'd0);
    check_result("rst", 1'b0, 8'h00, 16'h0000, 9'h000);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.s_ready", 32'(bus.s_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // backpressure, then a beat accepted right after the handshake
    send_beat("bp", 1'b0, 8'd9, 16'hBEEF, 8'h10, 8'hA5);
    wait_valid(lat);
    check("bp.latency", 32'(lat), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp.hold_valid",  32'(bus.m_valid), 32'd1);
      check("bp.hold_sready", 32'(bus.s_ready), 32'd0);
      check("bp.hold_mean",   32'(bus.m_mean),  32'hBEEF);
      check("bp.hold_tag",    32'(bus.m_tag),   32'hA5);
    end
    handshake("bp");
    run_vec(vecs[1]);

    // reset lands in the 4th divider iteration of a divided beat
    send_beat("rst_div", 1'b1, 8'd200, 16'h6400, 8'h80, 8'hC3);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_div.m_valid", 32'(bus.m_valid), 32'd0);
    check_result("rst_div", 1'b0, 8'h00, 16'h0000, 9'h000);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_div.s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_div.m_valid2", 32'(bus.m_valid), 32'd0);
    run_vec(vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
